iter_alu: RTL and testbench
===========================

// Module: iter_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the ARM datapath; next generation of the combinational ADD/SUB/AND/ORR ALU.
//  Adds EOR, iterative unsigned MUL (low word) and UDIV with a Start/Busy/Done handshake; registers result and NZCV flags.
//  Sits in the execute stage; the control unit stalls on Busy and consumes ALUResult/ALUFlags on Done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4); MUL and UDIV iterate WIDTH cycles
// PORTS
//  CLK         in   1      single clock, rising edge
//  nRESET      in   1      asynchronous, active-low reset
//  Start       in   1      request; sampled only when Busy=0
//  Src_A       in   WIDTH  operand A (dividend for UDIV)
//  Src_B       in   WIDTH  operand B (divisor for UDIV)
//  ALUControl  in   3      000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UDIV, 110 EOR, 111 reserved
//  Busy        out  1      iterative op in progress; Start ignored
//  Done        out  1      one-cycle pulse; ALUResult/ALUFlags valid from this cycle
//  ALUResult   out  WIDTH  registered result, held until next Done
//  ALUFlags    out  4      registered {N,Z,C,V}, held until next Done
// BEHAVIOUR
//  Reset: nRESET low -> state IDLE, Busy=0, Done=0, ALUResult=0, ALUFlags=0, counter=0, in-flight op discarded.
//  States: IDLE, MUL, DIV. Busy = (state != IDLE). Done is registered and defaults to 0 each cycle.
//  Single-cycle ops (ADD/SUB/AND/ORR/EOR/reserved), Start=1 in IDLE at edge k:
//    - ALUResult/ALUFlags are written and Done=1 after edge k; state stays IDLE, so back-to-back Starts complete every cycle.
//  ADD: {C,R} = A + B (WIDTH+1 bits). SUB: {C,R} = A + ~B + 1, so C=1 means no borrow (ARM convention).
//  V for ADD: A[W-1]==B[W-1] && R[W-1]!=A[W-1]. V for SUB: A[W-1]!=B[W-1] && R[W-1]!=A[W-1].
//  AND/ORR/EOR: C=0, V=0. Reserved 111: R=0, flags=0100.
//  N=R[W-1] and Z=(R==0) for all ops.
//  MUL, Start in IDLE at edge k:
//    - Latch operands, go to MUL with count=WIDTH, product accumulator = 0.
//    - Each edge: if multiplier LSB is set, add the shifted multiplicand; shift; count-1.
//    - After edge k+WIDTH: ALUResult = low WIDTH bits of A*B, C=0, V=0, Done=1, state returns to IDLE.
//  UDIV, Start in IDLE at edge k with B!=0:
//    - Restoring divide, one quotient bit per edge.
//    - After edge k+WIDTH: ALUResult = A/B (truncated), C=0, V=0, Done=1, state returns to IDLE.
//    - Remainder is internal only.
//  UDIV with B==0: no iteration; after edge k ALUResult = all ones, flags N=1 Z=0 C=0 V=1, Done=1, state stays IDLE.
//  Start while Busy=1 is ignored entirely; operands and opcode are latched at accept, so input changes mid-op have no effect.
//  Start is accepted in the Done cycle of an iterative op, since Busy is already 0.
//  nRESET asserted mid-iteration: immediate abort, no Done pulse, outputs return to 0.
//  Counter is $clog2(WIDTH)+1 bits wide; no wrap occurs in normal operation.
// STRUCTURE
//  Shared package/header alu_pkg: ALUControl opcode localparams (ALU_ADD..ALU_EOR, ALU_RSVD), state encodings, flag bit indices.
//  One sub-module, iter_muldiv_core: shift/add and restoring-subtract datapath with count.
//  Top level keeps the FSM, single-cycle ops and output registers.
// TESTING
//  1. WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 -> R=0x80000000, NZCV=1001, Done one cycle after Start, Busy stays 0.
//  2. SUB 5 - 5 -> R=0, NZCV=0110; SUB 0 - 1 -> R=0xFFFFFFFF, NZCV=1000.
//  3. MUL 0x0000FFFF * 0x00010001 -> R=0xFFFFFFFF, NZCV=1000; Busy for 32 cycles, Done exactly 32 edges after accept.
//  4. UDIV 100 / 7 -> R=14 after 32 cycles; UDIV x / 0 -> R=0xFFFFFFFF, NZCV=1001, Done next cycle.
//  5. Start=1 with a new opcode during MUL Busy -> ignored, result unchanged; Start in the Done cycle -> accepted.
//  6. nRESET pulsed low at iteration 10 of UDIV -> Busy=0, Done never pulses, ALUResult=0 and ALUFlags=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes,
// FSM state encodings and NZCV flag bit positions.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_UDIV = 3'b101;
  localparam logic [2:0] ALU_EOR  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] mk_flags(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// Shift/add multiplier and restoring divider sharing one
// set of registers; one bit per step, WIDTH steps per op.
module iter_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             div_sel,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_nxt,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  // acc: product or remainder; opa: multiplicand or
  // quotient/dividend; opb: multiplier or divisor
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             mode_div;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] opa_nxt;
  logic [WIDTH-1:0] opb_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    rem_sh  = {acc, opa[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb};
    if (mode_div) begin
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        opa_nxt = {opa[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        opa_nxt = {opa[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = acc + (opb[0] ? opa : '0);
      opa_nxt = {opa[WIDTH-2:0], 1'b0};
      opb_nxt = {1'b0, opb[WIDTH-1:1]};
    end
  end

  assign res_nxt = mode_div ? opa_nxt : acc_nxt;
  assign last    = step && (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      mode_div <= 1'b0;
      count    <= '0;
    end else if (load) begin
      acc      <= '0;
      opa      <= a;
      opb      <= b;
      mode_div <= div_sel;
      count    <= CW'(WIDTH);
    end else if (step) begin
      acc   <= acc_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith
// ops plus iterative MUL/UDIV behind a Busy/Done handshake.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             Start,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic [2:0]       ALUControl,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  import alu_pkg::*;

  state_t state;

  logic             is_mul;
  logic             is_div;
  logic             div_zero;
  logic             accept;
  logic             iter_go;
  logic             core_last;
  logic [WIDTH-1:0] core_res;
  logic [3:0]       it_flags;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic [3:0]       sc_flags;

  assign is_mul   = (ALUControl == ALU_MUL);
  assign is_div   = (ALUControl == ALU_UDIV);
  assign div_zero = is_div && (Src_B == '0);
  assign accept   = Start && (state == S_IDLE);
  assign iter_go  = accept && (is_mul || (is_div && !div_zero));
  assign Busy     = (state != S_IDLE);

  // SUB reuses the adder as A + ~B + 1, so C means no borrow
  assign is_sub = (ALUControl == ALU_SUB);
  assign b_eff  = is_sub ? ~Src_B : Src_B;
  assign sum    = {1'b0, Src_A} + {1'b0, b_eff}
                + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (1'b1)
      (ALUControl == ALU_ADD): begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (Src_A[WIDTH-1] == Src_B[WIDTH-1])
              && (sum[WIDTH-1] != Src_A[WIDTH-1]);
      end
      (ALUControl == ALU_SUB): begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (Src_A[WIDTH-1] != Src_B[WIDTH-1])
              && (sum[WIDTH-1] != Src_A[WIDTH-1]);
      end
      (ALUControl == ALU_AND): sc_res = Src_A & Src_B;
      (ALUControl == ALU_ORR): sc_res = Src_A | Src_B;
      (ALUControl == ALU_EOR): sc_res = Src_A ^ Src_B;
      (ALUControl == ALU_UDIV): begin
        sc_res = '1;
        sc_v   = 1'b1;
      end
      default: sc_res = '0;
    endcase
    sc_flags = mk_flags(sc_res[WIDTH-1], sc_res == '0,
                        sc_c, sc_v);
  end

  assign it_flags = mk_flags(core_res[WIDTH-1],
                             core_res == '0, 1'b0, 1'b0);

  iter_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (CLK),
    .rst_n  (nRESET),
    .load   (iter_go),
    .div_sel(is_div),
    .step   (Busy),
    .a      (Src_A),
    .b      (Src_B),
    .res_nxt(core_res),
    .last   (core_last)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      Done      <= 1'b0;
      ALUResult <= '0;
      ALUFlags  <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (iter_go) begin
            state <= is_mul ? S_MUL : S_DIV;
          end else if (accept) begin
            ALUResult <= sc_res;
            ALUFlags  <= sc_flags;
            Done      <= 1'b1;
          end
        end
        S_MUL, S_DIV: begin
          if (core_last) begin
            ALUResult <= core_res;
            ALUFlags  <= it_flags;
            Done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: expected results queued
// at issue, matched against each Done pulse.
module tb_iter_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint LIM = 64'sd2147483648;

  logic         CLK = 1'b0;
  logic         nRESET = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] Src_A = '0;
  logic [W-1:0] Src_B = '0;
  logic [2:0]   ALUControl = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  iter_alu #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .Start     (Start),
    .Src_A     (Src_A),
    .Src_B     (Src_B),
    .ALUControl(ALUControl),
    .Busy      (Busy),
    .Done      (Done),
    .ALUResult (ALUResult),
    .ALUFlags  (ALUFlags)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input logic [2:0] op, input logic [W-1:0] a, b,
    output logic [W-1:0] r, output logic [3:0] f,
    output int lat);
    longint s;
    logic [63:0] p;
    logic c, v;
    c = 1'b0; v = 1'b0; lat = 0; r = '0;
    case (op)
      ALU_ADD: begin
        p = {32'b0, a} + {32'b0, b};
        r = p[W-1:0]; c = p[W];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s >= LIM) || (s < -LIM);
      end
      ALU_SUB: begin
        r = a - b; c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s >= LIM) || (s < -LIM);
      end
      ALU_AND: r = a & b;
      ALU_ORR: r = a | b;
      ALU_EOR: r = a ^ b;
      ALU_MUL: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[W-1:0]; lat = W;
      end
      ALU_UDIV: begin
        if (b == 0) begin r = '1; v = 1'b1; end
        else begin r = a / b; lat = W; end
      end
      default: r = '0;
    endcase
    f = {r[W-1], r == 0, c, v};
  endfunction

  // called just after a falling edge; returns after the next one
  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a, b,
                       input bit acc, output int due);
    logic [W-1:0] r;
    logic [3:0] f;
    int lat;
    Start = 1'b1; ALUControl = op; Src_A = a; Src_B = b;
    due = cyc + 1;
    if (acc) begin
      model(op, a, b, r, f, lat);
      due = cyc + 1 + lat;
      sb.push_back('{r, f, due});
    end
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_until(input int due);
    int n = 0;
    while (cyc < due && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (cyc < due) chk("wait_bound", 0, 1);
  endtask

  task automatic run(input logic [2:0] op,
                     input logic [W-1:0] a, b);
    int d;
    issue(op, a, b, 1'b1, d);
    wait_until(d);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (Done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result", ALUResult, e.r);
        chk("flags", ALUFlags, e.f);
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin
    int d, t0;
    logic [2:0] op;
    logic [W-1:0] a, b;
    repeat (3) @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_flags", ALUFlags, 0);
    nRESET = 1'b1;
    @(negedge CLK);

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, d);
    chk("add_busy", Busy, 0);
    issue(ALU_SUB, 32'd5, 32'd5, 1'b1, d);
    issue(ALU_SUB, 32'd0, 32'd1, 1'b1, d);
    issue(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, d);
    issue(ALU_ORR, 32'h8000_0000, 32'h0000_0001, 1'b1, d);
    issue(ALU_EOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, d);
    issue(ALU_RSVD, 32'h1234_5678, 32'h9, 1'b1, d);
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, d);
    @(negedge CLK);

    issue(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b1, t0);
    chk("mul_busy", Busy, 1);
    issue(ALU_ADD, 32'h1, 32'h2, 1'b0, d);
    issue(ALU_EOR, 32'h3, 32'h4, 1'b0, d);
    wait_until(t0);
    chk("mul_idle", Busy, 0);
    issue(ALU_UDIV, 32'd100, 32'd7, 1'b1, d);
    chk("div_busy", Busy, 1);
    wait_until(d);
    issue(ALU_UDIV, 32'd12345, 32'd0, 1'b1, d);
    chk("div0_busy", Busy, 0);
    issue(ALU_SUB, 32'h8000_0000, 32'h1, 1'b1, d);
    @(negedge CLK);

    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run(op, a, b);
    end
    run(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(ALU_UDIV, 32'hFFFF_FFFF, 32'h1);
    run(ALU_UDIV, 32'd3, 32'd10);
    run(ALU_ADD, 32'h1, 32'h1);

    issue(ALU_UDIV, 32'hDEAD_BEEF, 32'd3, 1'b1, d);
    repeat (9) @(negedge CLK);
    nRESET = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_result", ALUResult, 0);
    chk("abort_flags", ALUFlags, 0);
    sb.delete();
    @(negedge CLK);
    nRESET = 1'b1;
    repeat (40) @(negedge CLK);
    run(ALU_ORR, 32'h10, 32'h01);
    run(ALU_MUL, 32'd7, 32'd6);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
